// File: rtl/pool_pkg.sv
// Shared types for the streaming pooling layer: pooling mode encoding and
// the output-width rule used to size sum accumulators.
package pool_pkg;

   typedef enum logic [1:0] {
      POOL_MAX = 2'd0,
      POOL_MIN = 2'd1,
      POOL_SUM = 2'd2
   } pool_mode_e;

   // A window of N elements summed needs clog2(N) extra bits to never wrap.
   function automatic int pool_out_width(input int data_width, input int window);
      return (window > 1) ? data_width + $clog2(window) : data_width;
   endfunction

endpackage

// File: rtl/pool_stream_channel.sv
// One channel of the pooling layer: folds window elements into an accumulator
// and exposes the value including the current beat for the output register.
module pool_stream_channel
   import pool_pkg::*;
#(
   parameter int DATA_WIDTH = 6,
   parameter int OUT_WIDTH  = 10
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clear_i,
   input  logic                  beat_i,
   input  logic                  first_i,
   input  pool_mode_e            mode_i,
   input  logic [DATA_WIDTH-1:0] x_i,
   output logic [OUT_WIDTH-1:0]  acc_d_o
);

   logic [OUT_WIDTH-1:0] acc_q;
   logic [OUT_WIDTH-1:0] acc_d;
   logic [OUT_WIDTH-1:0] x_ext;

   assign x_ext = OUT_WIDTH'(x_i);

   always_comb begin
      acc_d = acc_q;
      if (first_i) begin
         acc_d = x_ext;
      end else begin
         case (mode_i)
            POOL_MIN: acc_d = (x_ext < acc_q) ? x_ext : acc_q;
            POOL_SUM: acc_d = acc_q + x_ext;
            default:  acc_d = (x_ext > acc_q) ? x_ext : acc_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
      end else if (clear_i) begin
         acc_q <= '0;
      end else if (beat_i) begin
         acc_q <= acc_d;
      end
   end

   assign acc_d_o = acc_d;

endmodule

// File: rtl/pooling_stream_layer.sv
// Streaming MAX/MIN/SUM pooling over MATRIX_DIM x MATRIX_DIM windows, one
// element of every channel per beat, with a single registered result slot.
module pooling_stream_layer
   import pool_pkg::*;
#(
   parameter int NUM_CHANNELS = 6,
   parameter int DATA_WIDTH   = 6,
   parameter int MATRIX_DIM   = 3,
   localparam int WINDOW      = MATRIX_DIM * MATRIX_DIM,
   localparam int OUT_WIDTH   = pool_out_width(DATA_WIDTH, WINDOW)
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic [1:0]                         mode,
   input  logic                               clear,
   input  logic                               in_valid,
   output logic                               in_ready,
   input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] in_data,
   output logic                               out_valid,
   input  logic                               out_ready,
   output logic [NUM_CHANNELS*OUT_WIDTH-1:0]  out_data
);

   localparam int CNT_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WINDOW - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   pool_mode_e       mode_q;
   pool_mode_e       mode_d;
   logic             out_valid_q;
   logic [NUM_CHANNELS-1:0][OUT_WIDTH-1:0] out_data_q;
   logic [NUM_CHANNELS-1:0][OUT_WIDTH-1:0] acc_nxt;

   logic accept;
   logic first;
   logic last;

   assign first = (cnt_q == '0);
   // The last beat is only held back when it would overwrite an unread result.
   assign in_ready = !clear && ((cnt_q != CNT_LAST) || !out_valid_q || out_ready);
   assign accept   = in_valid && in_ready;
   assign last     = accept && (cnt_q == CNT_LAST);

   assign cnt_d  = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
   assign mode_d = (mode == 2'd3) ? POOL_MAX : pool_mode_e'(mode);

   for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
      pool_stream_channel #(
         .DATA_WIDTH (DATA_WIDTH),
         .OUT_WIDTH  (OUT_WIDTH)
      ) u_ch (
         .clk     (clk),
         .rst_n   (rst_n),
         .clear_i (clear),
         .beat_i  (accept),
         .first_i (first),
         .mode_i  (mode_q),
         .x_i     (in_data[g*DATA_WIDTH +: DATA_WIDTH]),
         .acc_d_o (acc_nxt[g])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         mode_q <= POOL_MAX;
      end else if (clear) begin
         cnt_q <= '0;
      end else if (accept) begin
         cnt_q <= cnt_d;
         if (first) begin
            mode_q <= mode_d;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else if (last) begin
         out_valid_q <= 1'b1;
         out_data_q  <= acc_nxt;
      end else if (out_valid_q && out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;

endmodule

// File: tb/tb_pooling_stream_layer.sv
// Bench for pooling_stream_layer: directed scenarios plus random traffic,
// checked every cycle against a window-level reference model.
module tb_pooling_stream_layer;

   localparam int NCH = 6;
   localparam int DW  = 6;
   localparam int W   = 9;
   localparam int OW  = 10;

   logic              clk;
   logic              rst_n;
   logic [1:0]        mode;
   logic              clear;
   logic              in_valid;
   logic              in_ready;
   logic [NCH*DW-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [NCH*OW-1:0] out_data;

   pooling_stream_layer #(
      .NUM_CHANNELS (NCH),
      .DATA_WIDTH   (DW),
      .MATRIX_DIM   (3)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .mode      (mode),
      .clear     (clear),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model state: elements of the window in progress, its mode,
   // and the queue of results the DUT still owes downstream.
   int                elems[NCH][W];
   int                mcnt = 0;
   int                mm   = 0;
   logic [NCH*OW-1:0] expq[$];
   logic              accepted;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
      end
   endtask

   function automatic logic [NCH*OW-1:0] model_result();
      logic [NCH*OW-1:0] v;
      int r;
      v = '0;
      for (int ch = 0; ch < NCH; ch++) begin
         r = elems[ch][0];
         for (int k = 1; k < W; k++) begin
            if (mm == 1)      r = (elems[ch][k] < r) ? elems[ch][k] : r;
            else if (mm == 2) r = r + elems[ch][k];
            else              r = (elems[ch][k] > r) ? elems[ch][k] : r;
         end
         v[ch*OW +: OW] = r[OW-1:0];
      end
      return v;
   endfunction

   task automatic tick();
      logic exp_rdy;
      @(negedge clk);
      chk("out_valid", 64'(out_valid), 64'(expq.size() != 0));
      if (expq.size() != 0) chk("out_data", 64'(out_data), 64'(expq[0]));
      exp_rdy = !clear && ((mcnt != W - 1) || (expq.size() == 0) || out_ready);
      chk("in_ready", 64'(in_ready), 64'(exp_rdy));
      accepted = in_valid && in_ready;
      if (out_valid && out_ready && expq.size() != 0) void'(expq.pop_front());
      if (clear) begin
         mcnt = 0;
      end else if (accepted) begin
         if (mcnt == 0) mm = int'(mode);
         for (int ch = 0; ch < NCH; ch++) elems[ch][mcnt] = int'(in_data[ch*DW +: DW]);
         mcnt++;
         if (mcnt == W) begin
            expq.push_back(model_result());
            mcnt = 0;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [NCH*DW-1:0] d);
      in_valid = 1'b1;
      in_data  = d;
      accepted = 1'b0;
      for (int t = 0; t < 50; t++) begin
         tick();
         if (accepted) break;
      end
      total++;
      assert (accepted) else begin
         bad++;
         $error("FAIL send_timeout observed=%0d expected=1", accepted);
      end
      in_valid = 1'b0;
   endtask

   function automatic logic [NCH*DW-1:0] rep(input int v);
      logic [DW-1:0] e;
      e = DW'(v);
      return {NCH{e}};
   endfunction

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'(0));
      chk("rst_out_data", 64'(out_data), 64'(0));
      mcnt = 0;
      expq.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      int ch0v[W];
      logic [NCH*DW-1:0] d;

      ch0v = '{5, 63, 2, 0, 7, 1, 9, 3, 4};
      rst_n = 1'b0; mode = 2'd0; clear = 1'b0; in_valid = 1'b0;
      in_data = '0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_out_valid", 64'(out_valid), 64'(0));
      chk("reset_out_data", 64'(out_data), 64'(0));
      rst_n = 1'b1;
      tick();

      // MAX window with a known channel 0 sequence
      mode = 2'd0;
      for (int k = 0; k < W; k++) begin
         d = {4'($urandom), $urandom};
         d[DW-1:0] = DW'(ch0v[k]);
         send(d);
      end
      chk("max_valid", 64'(out_valid), 64'(1));
      chk("max_ch0", 64'(out_data[OW-1:0]), 64'(63));
      tick();
      chk("max_pulse", 64'(out_valid), 64'(0));

      // SUM of all-63 must not wrap; MIN of descending values
      mode = 2'd2;
      for (int k = 0; k < W; k++) send(rep(63));
      for (int ch = 0; ch < NCH; ch++) chk("sum_567", 64'(out_data[ch*OW +: OW]), 64'(567));
      mode = 2'd1;
      for (int k = 0; k < W; k++) send(rep(9 - k));
      for (int ch = 0; ch < NCH; ch++) chk("min_1", 64'(out_data[ch*OW +: OW]), 64'(1));
      tick();

      // Backpressure: next window streams but its last beat waits
      mode = 2'd0;
      for (int k = 0; k < W - 1; k++) send(rep(k + 10));
      out_ready = 1'b0;
      send(rep(3));
      for (int k = 0; k < W - 1; k++) send(rep(k + 1));
      in_valid = 1'b1;
      in_data  = rep(40);
      repeat (3) begin
         tick();
         chk("stall_accept", 64'(accepted), 64'(0));
         chk("stall_hold", 64'(out_data[OW-1:0]), 64'(17));
      end
      out_ready = 1'b1;
      send(rep(40));
      chk("stall_new", 64'(out_data[OW-1:0]), 64'(40));
      tick();

      // Mode change mid-window only takes effect on the next window
      mode = 2'd0;
      for (int k = 0; k < W; k++) begin
         if (k == 4) mode = 2'd2;
         send(rep(k + 1));
      end
      chk("mode_latch_max", 64'(out_data[OW-1:0]), 64'(9));
      for (int k = 0; k < W; k++) send(rep(k + 1));
      chk("mode_next_sum", 64'(out_data[OW-1:0]), 64'(45));
      tick();

      // Clear drops the partial window
      mode = 2'd2;
      for (int k = 0; k < 4; k++) send(rep(1));
      clear = 1'b1;
      in_valid = 1'b1;
      tick();
      chk("clear_block", 64'(accepted), 64'(0));
      clear = 1'b0;
      for (int k = 0; k < W; k++) send(rep(1));
      chk("clear_sum9", 64'(out_data[OW-1:0]), 64'(9));
      tick();

      // Reset with a pending result and a partial window
      out_ready = 1'b0;
      for (int k = 0; k < W; k++) send(rep(5));
      for (int k = 0; k < 3; k++) send(rep(7));
      do_reset();
      out_ready = 1'b1;
      mode = 2'd2;
      for (int k = 0; k < W; k++) send(rep(2));
      chk("post_reset_sum", 64'(out_data[OW-1:0]), 64'(18));
      tick();

      // Random traffic against the model
      for (int i = 0; i < 400; i++) begin
         in_valid = ($urandom_range(0, 9) < 7);
         in_data  = {4'($urandom), $urandom};
         if ($urandom_range(0, 7) == 0) mode = 2'($urandom_range(0, 3));
         out_ready = ($urandom_range(0, 9) < 7);
         clear = ($urandom_range(0, 29) == 0);
         tick();
      end
      in_valid = 1'b0;
      clear = 1'b0;
      out_ready = 1'b1;
      repeat (4) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pooling_stream_layer.md
POOLING_STREAM_LAYER -- requirements
Module: pooling_stream_layer

Interface
REQ-001 SHALL have parameter NUM_CHANNELS, default 6, the number of parallel channels.
REQ-002 SHALL have parameter DATA_WIDTH, default 6, the unsigned bits per channel element.
REQ-003 SHALL have parameter MATRIX_DIM, default 3, the window edge; WINDOW = MATRIX_DIM*MATRIX_DIM elements per window.
REQ-004 SHALL derive localparam OUT_WIDTH = DATA_WIDTH + $clog2(WINDOW) (WINDOW=1 -> OUT_WIDTH = DATA_WIDTH).
REQ-005 SHALL use one clock and an asynchronous, active-low reset.
REQ-006 Ports:
- clk  in  1  clock.
- rst_n  in  1  async active-low reset.
- mode  in  2  pooling mode: 0 MAX, 1 MIN, 2 SUM, 3 reserved (treated as MAX).
- clear  in  1  sync abort; discards the partial window.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when high with in_valid.
- in_data  in  NUM_CHANNELS*DATA_WIDTH  one window element per channel; channel i at [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH].
- out_valid  out  1  pooled vector valid.
- out_ready  in  1  downstream accepts.
- out_data  out  NUM_CHANNELS*OUT_WIDTH  pooled result; channel i at [(i+1)*OUT_WIDTH-1 : i*OUT_WIDTH].

Function
REQ-007 SHALL accept one beat per cycle when in_valid && in_ready; one beat = element k (0..WINDOW-1, raster order) of every channel.
REQ-008 SHALL hold an element counter cnt (0..WINDOW-1); cnt increments on each accepted beat and wraps to 0 on the accepted beat where cnt == WINDOW-1.
REQ-009 SHALL latch mode on the accepted beat with cnt == 0; mode changes mid-window SHALL be ignored until the next window.
REQ-010 Per channel, the accumulator SHALL load the element on cnt == 0 and otherwise update: MAX -> max(acc,x); MIN -> min(acc,x); SUM -> acc+x. All comparisons are unsigned, and SUM SHALL NOT overflow at OUT_WIDTH.
REQ-011 MAX/MIN results SHALL be zero-extended to OUT_WIDTH.
REQ-012 On the accepted beat with cnt == WINDOW-1, the final value (including that beat) SHALL be written to out_data and out_valid set in the next cycle; latency is 1 cycle from last beat to out_valid.
REQ-013 out_data/out_valid SHALL remain stable while out_valid && !out_ready.
REQ-014 out_valid SHALL clear on out_valid && out_ready unless a new result is written in the same cycle, in which case it stays 1 with the new data.
REQ-015 in_ready = (cnt != WINDOW-1) || !out_valid || out_ready; non-final beats of the next window SHALL be accepted while a result is pending.
REQ-016 in_ready SHALL NOT depend combinationally on in_valid.
REQ-017 clear SHALL set cnt to 0 and drop the partial accumulation next cycle; it SHALL NOT affect a pending out_valid/out_data. A beat presented with clear high SHALL NOT be accepted (in_ready low while clear).
REQ-018 WINDOW == 1 SHALL work: every accepted beat produces a result.

Reset
REQ-019 On rst_n low, asynchronously: cnt = 0, out_valid = 0, out_data = 0, accumulators = 0, latched mode = MAX.
REQ-020 Reset mid-window or with a result pending SHALL discard both; the first accepted beat after release is element 0.

Structure
REQ-021 Package pool_pkg SHALL hold the mode enum (POOL_MAX, POOL_MIN, POOL_SUM) and a width helper for OUT_WIDTH.
REQ-022 The per-channel accumulate/compare logic SHALL be sub-module pool_stream_channel, instantiated NUM_CHANNELS times by generate; cnt, handshake and the output register are in the top.

Verification (NUM_CHANNELS=6, DATA_WIDTH=6, MATRIX_DIM=3, OUT_WIDTH=10)
REQ-023 MAX, ch0 elements 5,63,2,0,7,1,9,3,4, out_ready=1 -> ch0 out_data = 63 one cycle after the 9th beat, out_valid high for 1 cycle.
REQ-024 SUM, all channels all 63 for 9 beats -> every channel = 567 (no wrap); MIN with 9,8,...,1 -> 1.
REQ-025 out_ready=0 after a result, then stream the next window -> first 8 beats accepted, in_ready low on the 9th until out_ready rises; first result unchanged while stalled.
REQ-026 mode switched MAX->SUM at beat 4 -> the window still uses MAX; the next window uses SUM.
REQ-027 clear after 4 beats, then a full window of 1s in SUM -> result 9 (not 13); rst_n pulsed mid-window -> out_valid=0, out_data=0, and the next window is counted from element 0.
